// File: rtl/puf_pkg.sv
// puf_pkg: shared state encoding and default widths for the RO-compare PUF sequencer
package puf_pkg;
  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_HI,
    COUNT,
    DECIDE,
    DONE
  } puf_cmp_state_e;
  localparam int CNT_W_DEF  = 16;
  localparam int RESP_W_DEF = 32;
endpackage

// File: rtl/ro_edge_counter.sv
// ro_edge_counter: synchronises an async RO, detects rising edges, counts them saturating while gate is high
module ro_edge_counter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             gate,
  input  logic             ro_in,
  output logic [CNT_W-1:0] cnt
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rise;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ro_in};
    prev_d = sync_q[SYNC_STAGES-1];
    rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
    cnt_d  = clr ? '0 : (gate & rise & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/puf_ro_compare.sv
// puf_ro_compare: sequences the window timer, compares two RO edge counts per window and
// assembles a RESP_W-bit response presented on a valid/ready handshake
module puf_ro_compare
  import puf_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int RESP_W      = RESP_W_DEF,
  parameter int SEL_W       = 5,
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_MAX    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              timer_en,
  input  logic              window,
  output logic [SEL_W-1:0]  ro_sel,
  input  logic              ro_a,
  input  logic              ro_b,
  output logic              busy,
  output logic [RESP_W-1:0] resp,
  output logic [SEL_W:0]    tie_cnt,
  output logic              err,
  output logic              resp_valid,
  input  logic              resp_ready
);
  localparam int WW = $clog2(WAIT_MAX + 1);
  puf_cmp_state_e    state_q, state_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic [SEL_W:0]    tie_q, tie_d;
  logic              err_q, err_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_a, cnt_b;
  logic              gate, clr;
  // the WAIT_HI cycle that sees window rise is already inside the window, so it counts too
  assign gate = window & (state_q == WAIT_HI || state_q == COUNT);
  assign clr  = state_q == ARM;
  ro_edge_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_cnt_a (
    .clk(clk), .rst(rst), .clr(clr), .gate(gate), .ro_in(ro_a), .cnt(cnt_a)
  );
  ro_edge_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_cnt_b (
    .clk(clk), .rst(rst), .clr(clr), .gate(gate), .ro_in(ro_b), .cnt(cnt_b)
  );
  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    tie_d   = tie_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = ARM;
        resp_d  = '0;
        tie_d   = '0;
        err_d   = 1'b0;
        idx_d   = '0;
      end
      ARM: begin
        wait_d  = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (window) state_d = COUNT;
        else if (wait_q == WW'(WAIT_MAX - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else wait_d = wait_q + 1'b1;
      end
      COUNT: if (!window) state_d = DECIDE;
      DECIDE: begin
        resp_d[idx_q] = cnt_a > cnt_b;
        if (cnt_a == cnt_b) tie_d = tie_q + 1'b1;
        if (idx_q == SEL_W'(RESP_W - 1)) state_d = DONE;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = ARM;
        end
      end
      DONE: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      resp_q  <= '0;
      tie_q   <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      tie_q   <= tie_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
    end
  end
  assign timer_en   = state_q == ARM || state_q == WAIT_HI || state_q == COUNT;
  assign busy       = state_q != IDLE;
  assign resp_valid = state_q == DONE;
  assign ro_sel     = idx_q;
  assign resp       = resp_q;
  assign tie_cnt    = tie_q;
  assign err        = err_q;
endmodule

// File: tb/tb_puf_ro_compare.sv
// tb_puf_ro_compare: directed runs against a window-timer model; expected responses are queued
// at stimulus time and popped by a monitor whenever resp_valid rises
module tb_puf_ro_compare;
  typedef struct packed {
    logic [3:0] resp;
    logic [2:0] tie;
    logic       err;
  } exp_t;
  logic clk = 0, rst = 0, start = 0, start_s = 0, resp_ready = 1, ro_a = 0, ro_b = 0;
  logic window = 0, window_s = 0;
  logic timer_en, timer_en_s, busy, busy_s, err, err_s, resp_valid, resp_valid_s;
  logic [1:0] ro_sel, ro_sel_s;
  logic [3:0] resp, resp_s;
  logic [2:0] tie_cnt, tie_cnt_s;
  int checks = 0, errors = 0;
  int ha = 20, hb = 30, tns = 0, tc = 0, tc_s = 0;
  bit win_en = 1;
  logic pv = 0, pv_s = 0;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  always #5 clk = ~clk;
  // RO half periods in ns; the +2 offset keeps toggles away from clock edges
  always #1 begin
    tns++;
    ro_a = ((tns + 2) / ha) % 2 == 1;
    ro_b = ((tns + 2) / hb) % 2 == 1;
  end
  // window timer model: registered window, high for 50 cycles starting one cycle after enable
  always @(posedge clk) begin
    if (!timer_en) begin tc <= 0; window <= 1'b0; end
    else begin tc <= tc + 1; window <= win_en && tc < 50; end
    if (!timer_en_s) begin tc_s <= 0; window_s <= 1'b0; end
    else begin tc_s <= tc_s + 1; window_s <= tc_s < 50; end
  end
  puf_ro_compare #(.CNT_W(16), .RESP_W(4), .SEL_W(2), .SYNC_STAGES(2), .WAIT_MAX(64)) dut (
    .clk(clk), .rst(rst), .start(start), .timer_en(timer_en), .window(window), .ro_sel(ro_sel),
    .ro_a(ro_a), .ro_b(ro_b), .busy(busy), .resp(resp), .tie_cnt(tie_cnt), .err(err),
    .resp_valid(resp_valid), .resp_ready(resp_ready)
  );
  puf_ro_compare #(.CNT_W(3), .RESP_W(4), .SEL_W(2), .SYNC_STAGES(2), .WAIT_MAX(64)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .timer_en(timer_en_s), .window(window_s), .ro_sel(ro_sel_s),
    .ro_a(ro_a), .ro_b(ro_b), .busy(busy_s), .resp(resp_s), .tie_cnt(tie_cnt_s), .err(err_s),
    .resp_valid(resp_valid_s), .resp_ready(resp_ready)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (resp_valid && !pv) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut_unexpected_valid: got resp_valid=1 expected no response");
      end else begin
        e0 = q0.pop_front();
        chk("dut_resp", 32'(resp), 32'(e0.resp));
        chk("dut_tie_cnt", 32'(tie_cnt), 32'(e0.tie));
        chk("dut_err", 32'(err), 32'(e0.err));
      end
    end
    if (resp_valid_s && !pv_s) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL sat_unexpected_valid: got resp_valid=1 expected no response");
      end else begin
        e1 = q1.pop_front();
        chk("sat_resp", 32'(resp_s), 32'(e1.resp));
        chk("sat_tie_cnt", 32'(tie_cnt_s), 32'(e1.tie));
        chk("sat_err", 32'(err_s), 32'(e1.err));
      end
    end
    pv   = resp_valid;
    pv_s = resp_valid_s;
  end
  task automatic go(input bit both);
    @(negedge clk);
    start = 1'b1;
    start_s = both;
    @(negedge clk);
    start = 1'b0;
    start_s = 1'b0;
  endtask
  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (!busy && !busy_s) return;
      @(negedge clk);
    end
    chk({name, "_timeout"}, 32'(busy), 32'd0);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_timer_en", 32'(timer_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp", 32'(resp), 0);
    chk("rst_tie_cnt", 32'(tie_cnt), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ro_sel", 32'(ro_sel), 0);
    rst = 1'b1;
    // faster A than B -> every bit 1
    ha = 20; hb = 30;
    q0.push_back('{4'hF, 3'd0, 1'b0});
    go(0);
    wait_idle("t1");
    chk("t1_ro_sel_end", 32'(ro_sel), 3);
    // swapped -> every bit 0
    ha = 30; hb = 20;
    q0.push_back('{4'h0, 3'd0, 1'b0});
    go(0);
    wait_idle("t2");
    // identical in-phase oscillators -> four ties
    ha = 25; hb = 25;
    q0.push_back('{4'h0, 3'd4, 1'b0});
    go(0);
    wait_idle("t3");
    // 3-bit counters saturate at 7 on both sides -> ties; 16-bit instance still resolves
    ha = 10; hb = 20;
    q0.push_back('{4'hF, 3'd0, 1'b0});
    q1.push_back('{4'h0, 3'd4, 1'b0});
    go(1);
    wait_idle("t4");
    // timeout: window never rises
    win_en = 1'b0;
    q0.push_back('{4'h0, 3'd0, 1'b1});
    go(0);
    n = 0;
    while (!resp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_valid_latency", 32'(n), 65);
    win_en = 1'b1;
    wait_idle("t5");
    // backpressure: output stable, start ignored while waiting
    resp_ready = 1'b0;
    ha = 20; hb = 30;
    q0.push_back('{4'hF, 3'd0, 1'b0});
    go(0);
    n = 0;
    while (!resp_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_valid_seen", 32'(resp_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_hold_valid", 32'(resp_valid), 1);
      chk("t6_hold_resp", 32'(resp), 32'hF);
      start = (i == 3 || i == 6);
    end
    start = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("t6_valid_drop", 32'(resp_valid), 0);
    chk("t6_idle", 32'(busy), 0);
    repeat (5) @(negedge clk);
    chk("t6_no_restart", 32'(busy), 0);
    chk("t6_resp_hold", 32'(resp), 32'hF);
    // reset mid-COUNT aborts silently
    go(0);
    n = 0;
    while (!window && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_timer_en", 32'(timer_en), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_valid", 32'(resp_valid), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    chk("t6_post_rst_busy", 32'(busy), 0);
    chk("queue_drained", 32'(q0.size() + q1.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
